// File: rtl/otter_ctrl_unit.sv
// otter_ctrl_unit: multi-cycle FSM + decoder for the OTTER RV32I core.
// In: CLK, RST_N, IR, BR_EQ/LT/LTU, INTR. Out: PC/RF/MEM/ALU selects+enables.
module otter_ctrl_unit #(
    parameter bit INTR_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] IR,
    input  logic        BR_EQ,
    input  logic        BR_LT,
    input  logic        BR_LTU,
    input  logic        INTR,
    output logic        PC_WE,
    output logic [2:0]  PC_SEL,
    output logic        RF_WE,
    output logic [1:0]  RF_WR_SEL,
    output logic        MEM_RDEN1,
    output logic        MEM_RDEN2,
    output logic        MEM_WE2,
    output logic [3:0]  ALU_FUNC,
    output logic        SRCA_SEL,
    output logic [1:0]  SRCB_SEL,
    output logic        INT_TAKEN,
    output logic        ILLEGAL
);

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_WB,
        ST_INTR
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    state_t      state;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        br_legal;
    logic        br_taken;
    logic        take_intr;
    state_t      exit_state;

    assign opcode = IR[6:0];
    assign funct3 = IR[14:12];

    // INTR only matters at the edge that ends an instruction
    assign take_intr  = INTR_EN && INTR;
    assign exit_state = take_intr ? ST_INTR : ST_FETCH;

    always_comb begin
        br_legal = 1'b1;
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = BR_EQ;
            3'b001:  br_taken = !BR_EQ;
            3'b100:  br_taken = BR_LT;
            3'b101:  br_taken = !BR_LT;
            3'b110:  br_taken = BR_LTU;
            3'b111:  br_taken = !BR_LTU;
            default: br_legal = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_FETCH;
        end else begin
            case (state)
                ST_FETCH: state <= ST_EXEC;
                ST_EXEC:  state <= (opcode == OPC_LOAD) ? ST_WB : exit_state;
                ST_WB:    state <= exit_state;
                default:  state <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        PC_WE     = 1'b0;
        PC_SEL    = 3'd0;
        RF_WE     = 1'b0;
        RF_WR_SEL = 2'd0;
        MEM_RDEN1 = 1'b0;
        MEM_RDEN2 = 1'b0;
        MEM_WE2   = 1'b0;
        ALU_FUNC  = 4'd0;
        SRCA_SEL  = 1'b0;
        SRCB_SEL  = 2'd0;
        INT_TAKEN = 1'b0;
        ILLEGAL   = 1'b0;
        // Outputs are forced quiet for the whole reset assertion
        if (RST_N) begin
            case (state)
                ST_FETCH: MEM_RDEN1 = 1'b1;
                ST_EXEC: begin
                    PC_WE = 1'b1;
                    case (opcode)
                        OPC_OP: begin
                            RF_WE     = 1'b1;
                            RF_WR_SEL = 2'd3;
                            ALU_FUNC  = {IR[30], funct3};
                        end
                        OPC_OPIMM: begin
                            RF_WE     = 1'b1;
                            RF_WR_SEL = 2'd3;
                            SRCB_SEL  = 2'd1;
                            // IR[30] is immediate data except for SRLI/SRAI
                            ALU_FUNC  = (funct3 == 3'b101) ?
                                        {IR[30], funct3} : {1'b0, funct3};
                        end
                        OPC_LUI: begin
                            RF_WE     = 1'b1;
                            RF_WR_SEL = 2'd3;
                            SRCA_SEL  = 1'b1;
                            ALU_FUNC  = 4'b1001;
                        end
                        OPC_AUIPC: begin
                            RF_WE     = 1'b1;
                            RF_WR_SEL = 2'd3;
                            SRCA_SEL  = 1'b1;
                            SRCB_SEL  = 2'd3;
                        end
                        OPC_JAL: begin
                            PC_SEL = 3'd3;
                            RF_WE  = 1'b1;
                        end
                        OPC_JALR: begin
                            PC_SEL = 3'd1;
                            RF_WE  = 1'b1;
                        end
                        OPC_LOAD: begin
                            SRCB_SEL  = 2'd1;
                            MEM_RDEN2 = 1'b1;
                        end
                        OPC_STORE: begin
                            SRCB_SEL = 2'd2;
                            MEM_WE2  = 1'b1;
                        end
                        OPC_BRANCH: begin
                            if (!br_legal)
                                ILLEGAL = 1'b1;
                            else if (br_taken)
                                PC_SEL = 3'd2;
                        end
                        default: ILLEGAL = 1'b1;
                    endcase
                end
                ST_WB: begin
                    RF_WE     = 1'b1;
                    RF_WR_SEL = 2'd2;
                end
                default: begin
                    PC_WE     = 1'b1;
                    PC_SEL    = 3'd4;
                    INT_TAKEN = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_otter_ctrl_unit.sv
// tb_otter_ctrl_unit: random + directed instruction sequences for
// otter_ctrl_unit, checked against a transaction-level model.
module tb_otter_ctrl_unit;

    typedef struct packed {
        logic       pc_we;
        logic [2:0] pc_sel;
        logic       rf_we;
        logic [1:0] rf_wr_sel;
        logic       rden1;
        logic       rden2;
        logic       we2;
        logic [3:0] alu;
        logic       srca;
        logic [1:0] srcb;
        logic       int_taken;
        logic       illegal;
    } outs_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] IR = '0;
    logic        BR_EQ = 1'b0;
    logic        BR_LT = 1'b0;
    logic        BR_LTU = 1'b0;
    logic        INTR = 1'b0;

    logic        pc_we, rf_we, rden1, rden2, we2, srca, int_taken, illegal;
    logic [2:0]  pc_sel;
    logic [1:0]  rf_wr_sel, srcb;
    logic [3:0]  alu;

    logic        pc_we0, rf_we0, rden10, rden20, we20, srca0, int_taken0;
    logic        illegal0;
    logic [2:0]  pc_sel0;
    logic [1:0]  rf_wr_sel0, srcb0;
    logic [3:0]  alu0;

    outs_t obs;
    int checks = 0;
    int errors = 0;

    assign obs = {pc_we, pc_sel, rf_we, rf_wr_sel, rden1, rden2, we2,
                  alu, srca, srcb, int_taken, illegal};

    always #5 CLK = ~CLK;

    otter_ctrl_unit #(.INTR_EN(1'b1)) dut (
        .CLK(CLK), .RST_N(RST_N), .IR(IR),
        .BR_EQ(BR_EQ), .BR_LT(BR_LT), .BR_LTU(BR_LTU), .INTR(INTR),
        .PC_WE(pc_we), .PC_SEL(pc_sel), .RF_WE(rf_we),
        .RF_WR_SEL(rf_wr_sel), .MEM_RDEN1(rden1), .MEM_RDEN2(rden2),
        .MEM_WE2(we2), .ALU_FUNC(alu), .SRCA_SEL(srca),
        .SRCB_SEL(srcb), .INT_TAKEN(int_taken), .ILLEGAL(illegal)
    );

    otter_ctrl_unit #(.INTR_EN(1'b0)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .IR(IR),
        .BR_EQ(BR_EQ), .BR_LT(BR_LT), .BR_LTU(BR_LTU), .INTR(INTR),
        .PC_WE(pc_we0), .PC_SEL(pc_sel0), .RF_WE(rf_we0),
        .RF_WR_SEL(rf_wr_sel0), .MEM_RDEN1(rden10), .MEM_RDEN2(rden20),
        .MEM_WE2(we20), .ALU_FUNC(alu0), .SRCA_SEL(srca0),
        .SRCB_SEL(srcb0), .INT_TAKEN(int_taken0), .ILLEGAL(illegal0)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h @%0t", tag, got, exp, $time);
        end
    endtask

    // Instance with interrupts disabled must never enter the trap path
    always @(negedge CLK) begin
        if (RST_N)
            check("noint", {30'd0, int_taken0, pc_sel0 == 3'd4}, 32'd0);
    end

    function automatic outs_t exp_fetch();
        outs_t o = '0;
        o.rden1 = 1'b1;
        return o;
    endfunction

    function automatic outs_t exp_wb();
        outs_t o = '0;
        o.rf_we = 1'b1;
        o.rf_wr_sel = 2'd2;
        return o;
    endfunction

    function automatic outs_t exp_intr();
        outs_t o = '0;
        o.pc_we = 1'b1;
        o.pc_sel = 3'd4;
        o.int_taken = 1'b1;
        return o;
    endfunction

    // Execute-cycle behaviour from the instruction and the actual
    // rs1/rs2 operand values (branch outcome from real comparisons)
    function automatic outs_t exp_exec(logic [31:0] ir, logic [31:0] a,
                                       logic [31:0] b);
        outs_t o = '0;
        logic [2:0] f3 = ir[14:12];
        o.pc_we = 1'b1;
        case (ir[6:0])
            7'h33: begin
                o.rf_we = 1; o.rf_wr_sel = 3; o.alu = {ir[30], f3};
            end
            7'h13: begin
                o.rf_we = 1; o.rf_wr_sel = 3; o.srcb = 1;
                o.alu = (f3 == 3'd5) ? {ir[30], f3} : {1'b0, f3};
            end
            7'h37: begin
                o.rf_we = 1; o.rf_wr_sel = 3; o.srca = 1; o.alu = 4'd9;
            end
            7'h17: begin
                o.rf_we = 1; o.rf_wr_sel = 3; o.srca = 1; o.srcb = 3;
            end
            7'h6F: begin o.rf_we = 1; o.pc_sel = 3; end
            7'h67: begin o.rf_we = 1; o.pc_sel = 1; end
            7'h03: begin o.rden2 = 1; o.srcb = 1; end
            7'h23: begin o.we2 = 1; o.srcb = 2; end
            7'h63: begin
                bit t = 0;
                case (f3)
                    3'd0: t = (a == b);
                    3'd1: t = (a != b);
                    3'd4: t = ($signed(a) < $signed(b));
                    3'd5: t = ($signed(a) >= $signed(b));
                    3'd6: t = (a < b);
                    3'd7: t = (a >= b);
                    default: o.illegal = 1;
                endcase
                if (t) o.pc_sel = 3'd2;
            end
            default: o.illegal = 1;
        endcase
        return o;
    endfunction

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
        BR_EQ  = (a == b);
        BR_LT  = ($signed(a) < $signed(b));
        BR_LTU = (a < b);
    endtask

    // Enter just after an edge with the DUT in fetch; leave the same way
    task automatic run_instr(input logic [31:0] ir, input logic [31:0] a,
                             input logic [31:0] b, input bit intr);
        bit is_load = (ir[6:0] == 7'h03);
        IR = $urandom;
        INTR = $urandom_range(0, 1);
        set_ops($urandom, $urandom);
        #1 check("fetch", obs, exp_fetch());
        @(posedge CLK); #1;
        IR = ir;
        set_ops(a, b);
        INTR = is_load ? 1'($urandom_range(0, 1)) : intr;
        #1 check("exec", obs, exp_exec(ir, a, b));
        if (is_load) begin
            @(posedge CLK); #1;
            INTR = intr;
            #1 check("wb", obs, exp_wb());
        end
        @(posedge CLK); #1;
        if (intr) begin
            INTR = $urandom_range(0, 1);
            #1 check("intr", obs, exp_intr());
            @(posedge CLK); #1;
        end
    endtask

    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F,
                            7'h67, 7'h03, 7'h23, 7'h63};

    initial begin
        #2 check("rst", obs, 32'd0);
        @(posedge CLK); #1;
        check("rst_hold", obs, 32'd0);
        RST_N = 1'b1;

        run_instr(32'h002081B3, 1, 2, 0);
        run_instr(32'h402081B3, 1, 2, 0);
        run_instr(32'h40335293, 1, 2, 0);
        run_instr(32'h123450B7, 1, 2, 0);
        run_instr(32'h00812203, 1, 2, 0);
        run_instr(32'h00208463, 7, 7, 0);
        run_instr(32'h00208463, 7, 8, 0);
        run_instr(32'h002081B3, 1, 2, 1);
        run_instr(32'hFFFFFFFF, 1, 2, 0);
        run_instr(32'h0000A063, 1, 2, 0);

        // Reset asserted during load writeback
        IR = 32'h00812203;
        INTR = 1'b0;
        #1 check("lw_fetch", obs, exp_fetch());
        @(posedge CLK); #1;
        #1 check("lw_exec", obs, exp_exec(IR, 0, 0));
        @(posedge CLK); #1;
        #1 check("lw_wb", obs, exp_wb());
        RST_N = 1'b0;
        #1 check("rst_wb", obs, 32'd0);
        @(posedge CLK); #1;
        check("rst_wb_hold", obs, 32'd0);
        RST_N = 1'b1;

        for (int i = 0; i < 300; i++) begin
            logic [31:0] ir;
            logic [31:0] a;
            logic [31:0] b;
            int k;
            ir = $urandom;
            k = $urandom_range(0, 9);
            if (k < 9) ir[6:0] = ops[k];
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ 32'h8000_0000;
                default: b = $urandom;
            endcase
            run_instr(ir, a, b, $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule

// File: doc/otter_ctrl_unit.md
Name: otter_ctrl_unit

Overview:
Multi-cycle control unit for the OTTER RV32I core: FSM plus instruction decoder.
- Consumes the fetched instruction (IR) and the branch-condition flags.
- Sequences fetch, execute, writeback and interrupt entry.
- Encodes ALU_FUNC and all datapath mux selects and enables consumed by the ALU, register file, memory and PC.
- It is the producer side of the ALU_FUNC/SRC_A/SRC_B interface.

Parameters:
INTR_EN, 1, 1 enables interrupt entry; 0 ignores INTR.

Ports:
CLK  input  1  core clock, rising edge.
RST_N  input  1  asynchronous active-low reset.
IR  input  32  instruction word from memory port 1, valid in EXEC and WB.
BR_EQ  input  1  rs1 == rs2.
BR_LT  input  1  rs1 < rs2, signed.
BR_LTU  input  1  rs1 < rs2, unsigned.
INTR  input  1  level interrupt request.
PC_WE  output  1  PC load enable.
PC_SEL  output  3  0 PC+4, 1 JALR target, 2 branch target, 3 JAL target, 4 trap vector.
RF_WE  output  1  register-file write enable.
RF_WR_SEL  output  2  0 PC+4, 2 memory data, 3 ALU result.
MEM_RDEN1  output  1  instruction read enable.
MEM_RDEN2  output  1  data read enable.
MEM_WE2  output  1  data write enable.
ALU_FUNC  output  4  ALU opcode.
SRCA_SEL  output  1  0 rs1, 1 U-immediate.
SRCB_SEL  output  2  0 rs2, 1 I-immediate, 2 S-immediate, 3 PC.
INT_TAKEN  output  1  one-cycle pulse on interrupt entry.
ILLEGAL  output  1  one-cycle pulse in EXEC for an undecodable instruction.

Behaviour:
- States: FETCH, EXEC, WB, INTR. RST_N low asynchronously forces FETCH. While reset is held, every output is 0.
- Outputs are combinational from state and IR. Any output not listed as active in the current state is 0.
- FETCH: MEM_RDEN1=1. Next state EXEC.
- EXEC, decoded on IR[6:0]:
  - All legal opcodes assert PC_WE=1.
  - OP (0110011): RF_WE=1, RF_WR_SEL=3, SRCB_SEL=0, ALU_FUNC={IR[30],IR[14:12]}.
  - OP-IMM (0010011): RF_WE=1, RF_WR_SEL=3, SRCB_SEL=1. ALU_FUNC={IR[30],IR[14:12]} only when funct3=101; otherwise {0,IR[14:12]}.
  - LUI: ALU_FUNC=1001, SRCA_SEL=1, RF_WE=1, RF_WR_SEL=3.
  - AUIPC: ALU_FUNC=0000, SRCA_SEL=1, SRCB_SEL=3, RF_WE=1, RF_WR_SEL=3.
  - JAL: PC_SEL=3, RF_WE=1, RF_WR_SEL=0.
  - JALR: PC_SEL=1, RF_WE=1, RF_WR_SEL=0.
  - LOAD: ALU_FUNC=0000, SRCB_SEL=1, MEM_RDEN2=1, no RF_WE. Next state WB.
  - STORE: ALU_FUNC=0000, SRCB_SEL=2, MEM_WE2=1.
  - BRANCH: PC_SEL=2 if taken, else 0. Taken conditions: 000 BR_EQ, 001 !BR_EQ, 100 BR_LT, 101 !BR_LT, 110 BR_LTU, 111 !BR_LTU.
- Illegal instruction (any other opcode, or branch funct3 010/011): PC_WE=1, PC_SEL=0, ILLEGAL=1, no RF/MEM writes.
- WB: RF_WE=1, RF_WR_SEL=2.
- Exit from EXEC (non-load) or WB: next state INTR if INTR_EN and INTR, else FETCH. INTR is sampled at that clock edge only.
- INTR: PC_WE=1, PC_SEL=4, INT_TAKEN=1. Next state FETCH. INTR held high re-enters only after the next instruction completes.
- Latency: 2 cycles per instruction, 3 for loads, plus 1 for interrupt entry.
- Reset mid-instruction abandons it with no partial writes. After release, FETCH is entered on the first edge.

Test Plan:
- Reset, then IR=0x002081B3 (ADD) -> FETCH: MEM_RDEN1=1; EXEC: ALU_FUNC=0000, RF_WE=1, RF_WR_SEL=3, PC_WE=1, PC_SEL=0; back to FETCH.
- IR=0x402081B3 (SUB) -> ALU_FUNC=1000. IR=0x40335293 (SRAI) -> ALU_FUNC=1101, SRCB_SEL=1. IR=0x123450B7 (LUI) -> ALU_FUNC=1001, SRCA_SEL=1.
- IR=0x00812203 (LW) -> EXEC: MEM_RDEN2=1, ALU_FUNC=0000, SRCB_SEL=1, RF_WE=0; WB: RF_WE=1, RF_WR_SEL=2; then FETCH, 3 cycles total.
- IR=0x00208463 (BEQ) with BR_EQ=1 -> PC_SEL=2; with BR_EQ=0 -> PC_SEL=0. PC_WE=1 in both cases, RF_WE=0.
- INTR=1 during EXEC of ADD -> next state INTR: INT_TAKEN=1, PC_SEL=4, PC_WE=1, then FETCH. With INTR_EN=0 -> INT_TAKEN never asserts.
- IR=0xFFFFFFFF -> ILLEGAL=1 for one cycle, PC_SEL=0, RF_WE=MEM_WE2=0. RST_N low during WB of LW -> all outputs 0 immediately; after release, FETCH.
